ftdi_fifo_responder: RTL
========================

Name: ftdi_fifo_responder

Overview:
Synthesizable model of the device end of the FTDI asynchronous 245-FIFO interface: drives rxf_n/txe_n, answers rd_n strobes with bytes and captures bytes on wr_n strobes. It replaces the physical FTDI chip for on-FPGA loopback and for bench verification of the FPGA-side FTDI interface. On the host side it exposes two byte streams with valid/ready handshakes and buffers each direction in an internal FIFO.

Parameters:
DEPTH, 16, entries per direction FIFO; power of 2, minimum 2
RD_RECOVER, 2, cycles rxf_n is forced high after each read strobe completes
WR_RECOVER, 2, cycles txe_n is forced high after each write strobe completes

Ports:
clock  in  1  sole clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear: same effect as reset
rd_n  in  1  FPGA read strobe, active low
wr_n  in  1  FPGA write strobe, active low
adbus_in  in  8  data driven by FPGA during a write
adbus_out  out  8  data presented to FPGA during a read
adbus_oe  out  1  responder drives the bus
rxf_n  out  1  low = byte available to read
txe_n  out  1  low = space available to write
h_rx_data  in  8  host byte toward FPGA
h_rx_valid  in  1  host byte valid
h_rx_ready  out  1  RX FIFO can accept
h_tx_data  out  8  byte written by FPGA, toward host
h_tx_valid  out  1  TX FIFO non-empty
h_tx_ready  in  1  host accepts h_tx_data
rx_count  out  $clog2(DEPTH+1)  RX FIFO occupancy
tx_count  out  $clog2(DEPTH+1)  TX FIFO occupancy
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset/clear: both FIFOs empty, FSMs idle, recovery counters 0, proto_err 0. Outputs: rxf_n 1, txe_n 0, adbus_oe 0, adbus_out 0, h_rx_ready 1, h_tx_valid 0, counts 0. Reset mid-strobe abandons the transfer: no pop, no push.
- rd_n, wr_n, adbus_in are used as synchronous inputs in the clock domain. No synchronizers.
- RX FSM states: RX_IDLE, RX_HOLD, RX_RECOVER.
  - RX_IDLE: rxf_n = (rx_count == 0). adbus_out tracks the FIFO head, registered.
  - RX_IDLE with rd_n sampled 0 and rxf_n 0: pop the head, freeze adbus_out at the popped byte, go to RX_HOLD.
  - RX_HOLD: rxf_n 1. Stay while rd_n = 0. When rd_n = 1, go to RX_RECOVER and load the counter with RD_RECOVER.
  - RX_RECOVER: rxf_n 1. Decrement the counter and go to RX_IDLE at 0. If RD_RECOVER = 0, go directly from RX_HOLD to RX_IDLE.
- adbus_oe = ~rd_n, combinational in every state. The data byte is therefore valid in the same cycle as a 1-cycle rd_n pulse.
- rd_n low in RX_IDLE while rxf_n = 1: set proto_err, no pop, adbus_out unchanged.
- TX FSM states: TX_IDLE, TX_HOLD, TX_RECOVER.
  - TX_IDLE: txe_n = (tx_count == DEPTH).
  - TX_IDLE with wr_n sampled 0 and txe_n 0: push adbus_in from that same edge, go to TX_HOLD.
  - TX_HOLD: txe_n 1. Stay while wr_n = 0; the byte is captured once per strobe. When wr_n = 1, go to TX_RECOVER with WR_RECOVER, then return to TX_IDLE, mirroring the RX FSM.
  - wr_n low in TX_IDLE while txe_n = 1: set proto_err, byte dropped.
- rd_n and wr_n both low in the same cycle: set proto_err. Both FSMs still act independently.
- proto_err clears only on reset or clear.
- Host RX: h_rx_ready = (rx_count < DEPTH). Push on h_rx_valid & h_rx_ready.
- Host TX: h_tx_data = TX head. Pop on h_tx_valid & h_tx_ready.
- Push and pop in the same cycle on either FIFO: count unchanged, data order preserved. No bypass: an empty FIFO never forwards in the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts saturate by construction (push is gated at full, pop at empty).

Test Plan:
- Reset, then push host bytes 0xA5, 0x3C; FPGA issues 1-cycle rd_n pulses after each rxf_n fall -> adbus_out reads 0xA5 then 0x3C. rxf_n is high for exactly 1+RD_RECOVER cycles after each pulse. rx_count goes 2→1→0.
- FPGA holds wr_n low for 2 cycles with adbus_in = 0x7E, then 0x81 -> exactly two TX entries, 0x7E then 0x81, on h_tx_data. txe_n is high from the first low-sampled edge until WR_RECOVER cycles after wr_n rises.
- Fill TX with DEPTH=16 writes while h_tx_ready = 0 -> txe_n stays 1. A 17th wr_n strobe sets proto_err and tx_count stays 16. Then one h_tx_ready pop -> txe_n returns to 0.
- Fill RX to 16 -> h_rx_ready = 0. Simultaneous host push attempt and FPGA read -> count 15, no byte lost. 40 bytes streamed through the wrap-around arrive in order.
- rd_n pulse while the RX FIFO is empty -> proto_err = 1, adbus_oe = 1 for that cycle, rx_count 0. Assert clear -> proto_err = 0.
- Assert reset_n low during RX_HOLD and again during TX_HOLD -> all outputs return to reset values immediately (asynchronously), and FIFO contents are discarded.

Source files
------------

// File: rtl/ftdi_fifo_responder_if.sv
// Bus bundle for the FTDI 245-FIFO responder: FPGA-side strobes/data plus the
// host-side byte streams. "slave" is the responder, "master" is whoever drives it.
interface ftdi_fifo_responder_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          rd_n;
  logic          wr_n;
  logic [7:0]    adbus_in;
  logic [7:0]    adbus_out;
  logic          adbus_oe;
  logic          rxf_n;
  logic          txe_n;
  logic [7:0]    h_rx_data;
  logic          h_rx_valid;
  logic          h_rx_ready;
  logic [7:0]    h_tx_data;
  logic          h_tx_valid;
  logic          h_tx_ready;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic          proto_err;

  modport slave (
    input  rd_n, wr_n, adbus_in, h_rx_data, h_rx_valid, h_tx_ready,
    output adbus_out, adbus_oe, rxf_n, txe_n, h_rx_ready, h_tx_data,
           h_tx_valid, rx_count, tx_count, proto_err
  );

  modport master (
    output rd_n, wr_n, adbus_in, h_rx_data, h_rx_valid, h_tx_ready,
    input  adbus_out, adbus_oe, rxf_n, txe_n, h_rx_ready, h_tx_data,
           h_tx_valid, rx_count, tx_count, proto_err
  );
endinterface

// File: rtl/ftdi_fifo_responder.sv
// Device end of the FTDI asynchronous 245-FIFO interface with one buffered
// FIFO per direction between the FPGA strobes and the host byte streams.
module ftdi_fifo_responder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RD_RECOVER = 2,
  parameter int unsigned WR_RECOVER = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  ftdi_fifo_responder_if.slave  bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned RMAX = (RD_RECOVER > WR_RECOVER) ? RD_RECOVER : WR_RECOVER;
  localparam int unsigned RW   = $clog2(RMAX + 2);

  typedef enum logic [1:0] {RX_IDLE, RX_HOLD, RX_RECOVER} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_HOLD, TX_RECOVER} tx_state_t;

  rx_state_t     rx_state;
  tx_state_t     tx_state;
  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [RW-1:0] rd_rec, wr_rec;
  logic [7:0]    adbus_q;
  logic          perr;

  logic       rxf_n, txe_n;
  logic       rx_push, rx_pop, tx_push, tx_pop, err_now;
  logic       rx_refresh;
  logic [7:0] rx_head_next;

  always_comb begin
    rxf_n   = (rx_state != RX_IDLE) || (rx_cnt == '0);
    txe_n   = (tx_state != TX_IDLE) || (tx_cnt == CW'(DEPTH));
    rx_push = bus.h_rx_valid && (rx_cnt < CW'(DEPTH));
    rx_pop  = (rx_state == RX_IDLE) && !bus.rd_n && !rxf_n;
    tx_push = (tx_state == TX_IDLE) && !bus.wr_n && !txe_n;
    tx_pop  = (tx_cnt != '0) && bus.h_tx_ready;
    err_now = ((rx_state == RX_IDLE) && !bus.rd_n && rxf_n) ||
              ((tx_state == TX_IDLE) && !bus.wr_n && txe_n) ||
              (!bus.rd_n && !bus.wr_n);
    // adbus_out must already show the head on the first cycle rxf_n is low,
    // so the register loads the post-edge head (incl. a write into an empty FIFO).
    rx_refresh   = (rx_cnt != '0) || rx_push;
    rx_head_next = (rx_cnt == '0) ? bus.h_rx_data : rx_mem[rx_rp];
  end

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wp] <= bus.h_rx_data;
    if (tx_push) tx_mem[tx_wp] <= bus.adbus_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      rd_rec   <= '0;
      adbus_q  <= '0;
    end else if (clear) begin
      rx_state <= RX_IDLE;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      rd_rec   <= '0;
      adbus_q  <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      case (rx_state)
        RX_IDLE: begin
          if (rx_pop) begin
            adbus_q  <= rx_mem[rx_rp];
            rx_state <= RX_HOLD;
          end else if (rx_refresh) begin
            adbus_q <= rx_head_next;
          end
        end
        RX_HOLD: begin
          if (bus.rd_n) begin
            if (RD_RECOVER == 0) begin
              rx_state <= RX_IDLE;
              if (rx_refresh) adbus_q <= rx_head_next;
            end else begin
              rx_state <= RX_RECOVER;
              rd_rec   <= RW'(RD_RECOVER);
            end
          end
        end
        RX_RECOVER: begin
          if (rd_rec <= RW'(1)) begin
            rd_rec   <= '0;
            rx_state <= RX_IDLE;
            if (rx_refresh) adbus_q <= rx_head_next;
          end else begin
            rd_rec <= rd_rec - RW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_cnt   <= '0;
      wr_rec   <= '0;
    end else if (clear) begin
      tx_state <= TX_IDLE;
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_cnt   <= '0;
      wr_rec   <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      case (tx_state)
        TX_IDLE: if (tx_push) tx_state <= TX_HOLD;
        TX_HOLD: begin
          if (bus.wr_n) begin
            if (WR_RECOVER == 0) begin
              tx_state <= TX_IDLE;
            end else begin
              tx_state <= TX_RECOVER;
              wr_rec   <= RW'(WR_RECOVER);
            end
          end
        end
        TX_RECOVER: begin
          if (wr_rec <= RW'(1)) begin
            wr_rec   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            wr_rec <= wr_rec - RW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     perr <= 1'b0;
    else if (clear)   perr <= 1'b0;
    else if (err_now) perr <= 1'b1;
  end

  assign bus.adbus_out  = adbus_q;
  assign bus.adbus_oe   = ~bus.rd_n;
  assign bus.rxf_n      = rxf_n;
  assign bus.txe_n      = txe_n;
  assign bus.h_rx_ready = (rx_cnt < CW'(DEPTH));
  assign bus.h_tx_data  = tx_mem[tx_rp];
  assign bus.h_tx_valid = (tx_cnt != '0);
  assign bus.rx_count   = rx_cnt;
  assign bus.tx_count   = tx_cnt;
  assign bus.proto_err  = perr;
endmodule
